// File: rtl/euler_input_interpolator_if.sv
// Handshake and RAM port bundle between the input interpolator, the Euler
// stepper (enable/done) and the shared RAM (one read port, one write port).
// The master modport is the interpolator's view. The slave modport is the
// stepper/RAM side.
interface euler_input_interpolator_if #(
    parameter int ADDRESS_WIDTH = 13,
    parameter int DATA_WIDTH    = 64
);
    logic                     Interpolate_Enable;
    logic                     Interpolate_DONE;
    logic [ADDRESS_WIDTH-1:0] RAM_ADD_RD;
    logic [DATA_WIDTH-1:0]    RAM_DATA_RD;
    logic [ADDRESS_WIDTH-1:0] RAM_ADD_WR;
    logic [DATA_WIDTH-1:0]    RAM_DATA_WR;
    logic                     RAM_ENABLE_WR;

    modport master (
        input  Interpolate_Enable,
        input  RAM_DATA_RD,
        output Interpolate_DONE,
        output RAM_ADD_RD,
        output RAM_ADD_WR,
        output RAM_DATA_WR,
        output RAM_ENABLE_WR
    );

    modport slave (
        output Interpolate_Enable,
        output RAM_DATA_RD,
        input  Interpolate_DONE,
        input  RAM_ADD_RD,
        input  RAM_ADD_WR,
        input  RAM_DATA_WR,
        input  RAM_ENABLE_WR
    );
endinterface

// File: rtl/euler_input_interpolator.sv
// Euler input interpolator. It builds U(t) in shared RAM by linear
// interpolation between the stored samples U0 (taken at t0) and U1 (taken at t1).
// The 16-bit weight w = ((t-t0)<<16)/(t1-t0) comes from a serial restoring
// divider. When t falls outside (t0, t1) the weight is clamped instead.
// Optional build macro INTERP_ROUND_EN: round-half-up on the >>>16 shift.
// Without the macro, the shift truncates.
module euler_input_interpolator #(
    parameter int ADDRESS_WIDTH = 13,
    parameter int DATA_WIDTH    = 64,
    parameter int M_ADD         = 1,
    parameter int T_ADD         = 5457,
    parameter int US0_ADD       = 5460,
    parameter int US1_ADD       = 5510,
    parameter int U_ADD         = 5257
) (
    input  logic                        CLK,
    input  logic                        RST_N,
    euler_input_interpolator_if.master  bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LD_M,
        S_LD_T,
        S_WEIGHT,
        S_EL_RD0,   // present U0[i] address
        S_EL_RD1,   // latch U0[i], present U1[i] address
        S_EL_WR,    // U1[i] on read bus, write U[i]
        S_FIN
    } state_t;

    localparam logic [ADDRESS_WIDTH-1:0] M_A   = ADDRESS_WIDTH'(M_ADD);
    localparam logic [ADDRESS_WIDTH-1:0] T_A0  = ADDRESS_WIDTH'(T_ADD);
    localparam logic [ADDRESS_WIDTH-1:0] T_A1  = ADDRESS_WIDTH'(T_ADD + 1);
    localparam logic [ADDRESS_WIDTH-1:0] T_A2  = ADDRESS_WIDTH'(T_ADD + 2);
    localparam logic [ADDRESS_WIDTH-1:0] US0_A = ADDRESS_WIDTH'(US0_ADD);
    localparam logic [ADDRESS_WIDTH-1:0] US1_A = ADDRESS_WIDTH'(US1_ADD);
    localparam logic [ADDRESS_WIDTH-1:0] U_A   = ADDRESS_WIDTH'(U_ADD);

    state_t                   state_q, state_d;
    logic [15:0]              m_q, m_d;
    logic [15:0]              t0_q, t0_d;
    logic [15:0]              t1_q, t1_d;
    logic [15:0]              t_q, t_d;
    logic [15:0]              w_q, w_d;
    logic                     sel_u1_q, sel_u1_d;
    logic [15:0]              rem_q, rem_d;
    logic [3:0]               cnt_q, cnt_d;
    logic [15:0]              idx_q, idx_d;
    logic [15:0]              u0_q, u0_d;
    logic [ADDRESS_WIDTH-1:0] rd_addr_q, rd_addr_d;

    logic                     enable;
    logic [15:0]              rd16;
    logic                     wr_en;
    logic                     weight_done;

    // Divider step signals.
    logic [15:0]              span;
    logic [15:0]              rem_in;
    logic [16:0]              rem_sh;
    logic                     q_bit;
    logic [15:0]              rem_next;

    // Interpolation datapath signals.
    logic signed [16:0]       diff;
    logic signed [33:0]       prod;
    logic signed [33:0]       prod_adj;
    logic [15:0]              u_val;
    logic                     unused_bits;

    assign enable = bus.Interpolate_Enable;
    assign rd16   = bus.RAM_DATA_RD[15:0];

    // Only the low 16 bits of a word are arithmetic. The shift keeps product bits [31:16].
    assign unused_bits = ^{bus.RAM_DATA_RD[DATA_WIDTH-1:16], prod_adj[33:32], prod_adj[15:0]};

    // One restoring-division step. The dividend's low half is all zeros, so a 0 shifts in.
    // On the first step the partial remainder starts at t - t0, which is < span.
    always_comb begin
        span     = t1_q - t0_q;
        rem_in   = (cnt_q == 4'd0) ? (t_q - t0_q) : rem_q;
        rem_sh   = {rem_in, 1'b0};
        q_bit    = (rem_sh >= {1'b0, span});
        rem_next = q_bit ? 16'(rem_sh - {1'b0, span}) : rem_sh[15:0];
    end

    // U = U0 + ((U1-U0)*w >>> 16). U1 is taken straight off the read bus during the write cycle.
    always_comb begin
        diff = $signed({1'b0, rd16}) - $signed({1'b0, u0_q});
        prod = $signed({{17{diff[16]}}, diff}) * $signed({18'b0, w_q});
`ifdef INTERP_ROUND_EN
        prod_adj = prod + 34'sd32768;
`else
        prod_adj = prod;
`endif
        u_val = sel_u1_q ? rd16 : (u0_q + prod_adj[31:16]);
    end

    // Next-state logic and datapath updates. Any enable drop before FIN aborts to IDLE.
    always_comb begin
        // NOTE: every variable gets a default first, so no path through the case infers a latch.
        state_d     = state_q;
        m_d         = m_q;
        t0_d        = t0_q;
        t1_d        = t1_q;
        t_d         = t_q;
        w_d         = w_q;
        sel_u1_d    = sel_u1_q;
        rem_d       = rem_q;
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        u0_d        = u0_q;
        rd_addr_d   = rd_addr_q;
        wr_en       = 1'b0;
        weight_done = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (enable) begin
                    rd_addr_d = M_A;
                    state_d   = S_LD_M;
                end
            end

            S_LD_M: begin
                if (!enable) begin
                    state_d = S_IDLE;
                end else begin
                    m_d       = rd16;
                    rd_addr_d = T_A0;
                    cnt_d     = 4'd0;
                    state_d   = S_LD_T;
                end
            end

            S_LD_T: begin
                if (!enable) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                    case (cnt_q)
                        4'd0: begin
                            t0_d      = rd16;
                            rd_addr_d = T_A1;
                        end
                        4'd1: begin
                            t1_d      = rd16;
                            rd_addr_d = T_A2;
                        end
                        default: begin
                            t_d     = rd16;
                            cnt_d   = 4'd0;
                            state_d = S_WEIGHT;
                        end
                    endcase
                end
            end

            S_WEIGHT: begin
                if (!enable) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                    if (cnt_q == 4'd0 && (t1_q <= t0_q || t_q <= t0_q)) begin
                        w_d         = 16'h0000;
                        sel_u1_d    = 1'b0;
                        weight_done = 1'b1;
                    end else if (cnt_q == 4'd0 && t_q >= t1_q) begin
                        w_d         = 16'hFFFF;
                        sel_u1_d    = 1'b1;
                        weight_done = 1'b1;
                    end else begin
                        w_d         = {w_q[14:0], q_bit};
                        rem_d       = rem_next;
                        sel_u1_d    = 1'b0;
                        weight_done = (cnt_q == 4'd15);
                    end
                    if (weight_done) begin
                        idx_d   = 16'd0;
                        cnt_d   = 4'd0;
                        state_d = (m_q == 16'd0) ? S_FIN : S_EL_RD0;
                    end
                end
            end

            S_EL_RD0: begin
                if (!enable) begin
                    state_d = S_IDLE;
                end else begin
                    rd_addr_d = US0_A + ADDRESS_WIDTH'(idx_q);
                    state_d   = S_EL_RD1;
                end
            end

            S_EL_RD1: begin
                if (!enable) begin
                    state_d = S_IDLE;
                end else begin
                    u0_d      = rd16;
                    rd_addr_d = US1_A + ADDRESS_WIDTH'(idx_q);
                    state_d   = S_EL_WR;
                end
            end

            S_EL_WR: begin
                // The write already on the bus completes even if enable is dropping.
                wr_en = 1'b1;
                if (!enable) begin
                    state_d = S_IDLE;
                end else if (idx_q + 16'd1 == m_q) begin
                    state_d = S_FIN;
                end else begin
                    idx_d   = idx_q + 16'd1;
                    state_d = S_EL_RD0;
                end
            end

            S_FIN: begin
                if (!enable) begin
                    state_d = S_IDLE;
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers. Everything clears on reset.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q   <= S_IDLE;
            m_q       <= '0;
            t0_q      <= '0;
            t1_q      <= '0;
            t_q       <= '0;
            w_q       <= '0;
            sel_u1_q  <= 1'b0;
            rem_q     <= '0;
            cnt_q     <= '0;
            idx_q     <= '0;
            u0_q      <= '0;
            rd_addr_q <= '0;
        end else begin
            // NOTE: non-blocking assignments, so every register samples pre-edge values.
            state_q   <= state_d;
            m_q       <= m_d;
            t0_q      <= t0_d;
            t1_q      <= t1_d;
            t_q       <= t_d;
            w_q       <= w_d;
            sel_u1_q  <= sel_u1_d;
            rem_q     <= rem_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            u0_q      <= u0_d;
            rd_addr_q <= rd_addr_d;
        end
    end

    // The read address is driven in the issuing cycle, so the registered RAM
    // returns the word in the next cycle. When unused it holds its last value.
    // It is forced to 0 while reset is asserted.
    assign bus.RAM_ADD_RD       = RST_N ? rd_addr_d : '0;
    assign bus.RAM_ENABLE_WR    = wr_en;
    assign bus.RAM_ADD_WR       = wr_en ? (U_A + ADDRESS_WIDTH'(idx_q)) : '0;
    assign bus.RAM_DATA_WR      = wr_en ? {{(DATA_WIDTH-16){1'b0}}, u_val} : '0;
    assign bus.Interpolate_DONE = (state_q == S_FIN);

endmodule

// File: tb/tb_euler_input_interpolator.sv
// Self-checking bench for euler_input_interpolator. A registered RAM model
// feeds the read port. Each run pushes its expected writes into a scoreboard
// queue. A negedge monitor pops and compares every write strobe it sees.
module tb_euler_input_interpolator;

    localparam int AW      = 13;
    localparam int DW      = 64;
    localparam int M_ADD   = 1;
    localparam int T_ADD   = 5457;
    localparam int US0_ADD = 5460;
    localparam int US1_ADD = 5510;
    localparam int U_ADD   = 5257;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    euler_input_interpolator_if #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    euler_input_interpolator #(
        .ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .M_ADD(M_ADD), .T_ADD(T_ADD),
        .US0_ADD(US0_ADD), .US1_ADD(US1_ADD), .U_ADD(U_ADD)
    ) dut (
        .CLK  (clk),
        .RST_N(rst_n),
        .bus  (bus)
    );

    logic [DW-1:0] mem [0:8191];
    wr_t           exp_q[$];
    wr_t           mon_e;
    int            n_checks = 0;
    int            n_pass   = 0;
    int            n_writes = 0;
    int unsigned   u0_v [8];
    int unsigned   u1_v [8];

    // Registered read port: data for the address seen at an edge appears after that edge.
    always @(posedge clk) bus.RAM_DATA_RD <= mem[bus.RAM_ADD_RD];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Every write strobe must match the next expected write, in order.
    always @(negedge clk) begin
        if (bus.RAM_ENABLE_WR === 1'b1) begin
            n_writes++;
            check("write_expected", 64'(exp_q.size() != 0), 64'd1);
            if (exp_q.size() != 0) begin
                mon_e = exp_q.pop_front();
                check("wr_addr", 64'(bus.RAM_ADD_WR), 64'(mon_e.addr));
                check("wr_data", bus.RAM_DATA_WR, mon_e.data);
            end
        end
    end

    function automatic longint floor_div(input longint a, input longint b);
        if (a >= 0) return a / b;
        return -((-a + b - 1) / b);
    endfunction

    function automatic bit is_clamped(input int unsigned t0, input int unsigned t1, input int unsigned t);
        return (t1 <= t0) || (t <= t0) || (t >= t1);
    endfunction

    // Reference interpolation with plain integer arithmetic.
    function automatic logic [15:0] interp(input int unsigned t0, input int unsigned t1,
                                           input int unsigned t, input int unsigned u0,
                                           input int unsigned u1);
        longint w, p, q;
        if (t1 <= t0 || t <= t0) return 16'(u0);
        if (t >= t1) return 16'(u1);
        w = (longint'(t - t0) * 65536) / longint'(t1 - t0);
        p = (longint'(u1) - longint'(u0)) * w;
`ifdef INTERP_ROUND_EN
        q = floor_div(p + 32768, 65536);
`else
        q = floor_div(p, 65536);
`endif
        return 16'(longint'(u0) + q);
    endfunction

    function automatic logic [63:0] word(input int unsigned v);
        return {$urandom(), 16'($urandom()), 16'(v)};
    endfunction

    // Load m, the times and the samples into RAM. Queue the expected writes.
    task automatic load(input int m, input int unsigned t0, input int unsigned t1, input int unsigned t);
        mem[M_ADD]     = word(m);
        mem[T_ADD]     = word(t0);
        mem[T_ADD + 1] = word(t1);
        mem[T_ADD + 2] = word(t);
        for (int i = 0; i < m; i++) begin
            mem[US0_ADD + i] = word(u0_v[i]);
            mem[US1_ADD + i] = word(u1_v[i]);
            exp_q.push_back('{addr: AW'(U_ADD + i),
                              data: {48'h0, interp(t0, t1, t, u0_v[i], u1_v[i])}});
        end
    endtask

    task automatic run(input string tag, input int m, input int unsigned t0,
                       input int unsigned t1, input int unsigned t);
        int cyc;
        int tw;
        logic done;
        load(m, t0, t1, t);
        tw = is_clamped(t0, t1, t) ? 1 : 16;
        @(negedge clk);
        bus.Interpolate_Enable = 1'b1;
        cyc  = 0;
        done = 1'b0;
        while (!done && cyc < 200) begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
            done = bus.Interpolate_DONE;
        end
        check({tag, " latency"}, 64'(cyc), 64'(5 + tw + 3 * m));
        check({tag, " all_written"}, 64'(exp_q.size()), 64'd0);
        repeat (3) @(negedge clk);
        check({tag, " done_hold"}, 64'(bus.Interpolate_DONE), 64'd1);
        bus.Interpolate_Enable = 1'b0;
        @(negedge clk);
        check({tag, " done_clear"}, 64'(bus.Interpolate_DONE), 64'd0);
        exp_q.delete();
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, " done"},    64'(bus.Interpolate_DONE), 64'd0);
        check({tag, " wr_en"},   64'(bus.RAM_ENABLE_WR),    64'd0);
        check({tag, " add_rd"},  64'(bus.RAM_ADD_RD),       64'd0);
        check({tag, " add_wr"},  64'(bus.RAM_ADD_WR),       64'd0);
        check({tag, " data_wr"}, bus.RAM_DATA_WR,           64'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        int w0;
        int m;
        int unsigned t0, t1, t;
        logic done_seen;

        for (int i = 0; i < 8192; i++) mem[i] = '0;
        bus.Interpolate_Enable = 1'b1;   // enable high during reset must not leak out
        repeat (3) @(negedge clk);
        #1;
        check_outputs_zero("reset");
        bus.Interpolate_Enable = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("post_reset writes", 64'(n_writes), 64'd0);

        // Midpoint divide: w=0x8000 -> {150, 100}, 27 cycles.
        u0_v[0] = 100; u0_v[1] = 200; u1_v[0] = 200; u1_v[1] = 0;
        run("mid", 2, 0, 10, 5);
        // t == t1 selects U1 exactly.
        run("t_eq_t1", 2, 0, 10, 10);
        // t1 == t0 gives U0.
        run("t1_eq_t0", 2, 7, 7, 9);
        // m = 0: no writes, divide and clamp latency.
        run("m0_div", 0, 0, 10, 5);
        run("m0_clamp", 0, 4, 2, 3);
        // w = 21845: truncation gives 0, rounding gives 1.
        u0_v[0] = 0; u1_v[0] = 2;
        run("w21845", 1, 0, 3, 1);
        // Largest in-range t.
        u0_v[0] = 65535; u1_v[0] = 0; u0_v[1] = 1; u1_v[1] = 65535;
        run("t_near_t1", 2, 1000, 61000, 60999);

        // Abort: enable drops in element 1, phase c1. Only element 0 gets written.
        u0_v[0] = 10; u0_v[1] = 20; u0_v[2] = 30;
        u1_v[0] = 50; u1_v[1] = 60; u1_v[2] = 70;
        load(3, 0, 8, 3);
        void'(exp_q.pop_back());
        void'(exp_q.pop_back());
        w0 = n_writes;
        @(negedge clk);
        bus.Interpolate_Enable = 1'b1;
        repeat (25) @(posedge clk);
        @(negedge clk);
        bus.Interpolate_Enable = 1'b0;
        done_seen = 1'b0;
        repeat (12) begin
            @(negedge clk);
            done_seen = done_seen | bus.Interpolate_DONE;
        end
        check("abort writes", 64'(n_writes - w0), 64'd1);
        check("abort done", 64'(done_seen), 64'd0);
        check("abort pending", 64'(exp_q.size()), 64'd0);
        run("restart", 3, 0, 8, 3);

        // Reset in the middle of the divide: outputs drop at once, nothing written afterwards.
        u0_v[0] = 5; u1_v[0] = 9000; u0_v[1] = 77; u1_v[1] = 3;
        load(2, 100, 400, 250);
        @(negedge clk);
        bus.Interpolate_Enable = 1'b1;
        repeat (10) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_outputs_zero("mid_reset");
        bus.Interpolate_Enable = 1'b0;
        exp_q.delete();
        w0 = n_writes;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        done_seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            done_seen = done_seen | bus.Interpolate_DONE;
        end
        check("mid_reset writes", 64'(n_writes - w0), 64'd0);
        check("mid_reset done", 64'(done_seen), 64'd0);
        run("after_reset", 2, 100, 400, 250);

        // Random runs that cover in-range, t >= t1, t <= t0 and t1 <= t0.
        for (int k = 0; k < 25; k++) begin
            m  = int'($urandom_range(0, 6));
            t0 = $urandom_range(0, 20000);
            t1 = t0 + $urandom_range(1, 40000);
            case ($urandom_range(0, 3))
                0: t = (t1 > t0 + 1) ? $urandom_range(t0 + 1, t1 - 1) : t1;
                1: t = $urandom_range(t1, 65535);
                2: t = $urandom_range(0, t0);
                default: begin
                    t  = $urandom_range(0, 65535);
                    t1 = $urandom_range(0, t0);
                end
            endcase
            for (int i = 0; i < 8; i++) begin
                u0_v[i] = $urandom_range(0, 65535);
                u1_v[i] = $urandom_range(0, 65535);
            end
            run($sformatf("rand%0d", k), m, t0, t1, t);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
